// File: rtl/key_debounce.sv
// key_debounce: per-channel pushbutton synchronizer, debounce FSM and press/release pulse generator
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_pls_1k      one-cycle 1 ms tick
//   i_key         raw active-low key levels
//   o_key_lvl     debounced level, 1 = pressed
//   o_key_press   one-cycle pulse on accepted press
//   o_key_release one-cycle pulse on accepted release
module key_debounce #(
    parameter int NUM_KEY     = 4,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pls_1k,
    input  logic [NUM_KEY-1:0] i_key,
    output logic [NUM_KEY-1:0] o_key_lvl,
    output logic [NUM_KEY-1:0] o_key_press,
    output logic [NUM_KEY-1:0] o_key_release
);
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
    localparam logic [7:0] LAST = 8'(DEBOUNCE_MS - 1);
    for (genvar g = 0; g < NUM_KEY; g++) begin : g_ch
        logic [1:0] sync;
        logic [7:0] cnt, cnt_n;
        logic       key, lvl, press, rel;
        state_t     st, st_n;
        assign key = sync[1];
        assign o_key_lvl[g]     = lvl;
        assign o_key_press[g]   = press;
        assign o_key_release[g] = rel;
        // Key-level aborts are tested before the tick so a coincident tick is never counted.
        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            case (st)
                IDLE:
                    if (!key) begin
                        st_n  = PRESS_CHK;
                        cnt_n = '0;
                    end
                PRESS_CHK:
                    if (key) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end else if (i_pls_1k) begin
                        st_n  = cnt == LAST ? HELD : PRESS_CHK;
                        cnt_n = cnt == LAST ? 8'd0 : cnt + 8'd1;
                    end
                HELD:
                    if (key) begin
                        st_n  = REL_CHK;
                        cnt_n = '0;
                    end
                REL_CHK:
                    if (!key) begin
                        st_n  = HELD;
                        cnt_n = '0;
                    end else if (i_pls_1k) begin
                        st_n  = cnt == LAST ? IDLE : REL_CHK;
                        cnt_n = cnt == LAST ? 8'd0 : cnt + 8'd1;
                    end
                default: begin
                    st_n  = IDLE;
                    cnt_n = '0;
                end
            endcase
        end
        // Outputs are registered from the next state so they align with the state change.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                sync  <= 2'b11;
                st    <= IDLE;
                cnt   <= '0;
                lvl   <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                sync  <= {sync[0], i_key[g]};
                st    <= st_n;
                cnt   <= cnt_n;
                lvl   <= st_n == HELD || st_n == REL_CHK;
                press <= st == PRESS_CHK && st_n == HELD;
                rel   <= st == REL_CHK && st_n == IDLE;
            end
        end
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter: NUM_KEY, default 4, number of independent key channels.
REQ-002 Parameter: DEBOUNCE_MS, default 20, stable time in 1 ms ticks required to accept a change (legal range 2..255).
REQ-003 Port: i_clk  input  1  system clock, 10 MHz; all logic on rising edge.
REQ-004 Port: i_rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: i_pls_1k  input  1  1 kHz tick from the upstream pulse generator; high for one i_clk cycle per ms.
REQ-006 Port: i_key  input  NUM_KEY  raw pushbutton levels; asynchronous; active-low (0 = pressed).
REQ-007 Port: o_key_lvl  output  NUM_KEY  debounced level; active-high (1 = pressed).
REQ-008 Port: o_key_press  output  NUM_KEY  one-cycle pulse on accepted press.
REQ-009 Port: o_key_release  output  NUM_KEY  one-cycle pulse on accepted release.

Function
REQ-010 Each i_key bit SHALL pass through a 2-flop synchronizer before any other use; the synchronizer flops reset to 1 (released).
REQ-011 Each channel SHALL have its own 4-state FSM and 8-bit tick counter; channels are fully independent.
REQ-012 States: IDLE (stable released), PRESS_CHK, HELD (stable pressed), REL_CHK.
REQ-013 IDLE: synchronized key = 0 -> PRESS_CHK with counter cleared to 0; otherwise stay.
REQ-014 PRESS_CHK: synchronized key = 1 -> IDLE, counter cleared, no pulse (bounce rejected).
REQ-015 PRESS_CHK, key = 0, i_pls_1k = 1: counter increments; if counter = DEBOUNCE_MS-1 at that tick -> HELD, counter cleared.
REQ-016 HELD: synchronized key = 1 -> REL_CHK with counter cleared; otherwise stay.
REQ-017 REL_CHK: key = 0 -> HELD, counter cleared, no pulse.
REQ-018 REL_CHK, key = 1, i_pls_1k = 1: counter increments; if counter = DEBOUNCE_MS-1 at that tick -> IDLE, counter cleared.
REQ-019 When key level and i_pls_1k change in the same cycle, the key-level abort in REQ-014/REQ-017 SHALL take priority and the tick SHALL NOT be counted.
REQ-020 Each i_clk cycle with i_pls_1k = 1 SHALL count as one tick; no edge detection is performed.
REQ-021 o_key_lvl SHALL be registered; it is 1 while the FSM is in HELD or REL_CHK and 0 in IDLE or PRESS_CHK.
REQ-022 o_key_press SHALL be high for exactly one i_clk cycle: the cycle in which the FSM first shows HELD after PRESS_CHK.
REQ-023 o_key_release SHALL be high for exactly one i_clk cycle: the cycle in which the FSM first shows IDLE after REL_CHK.
REQ-024 o_key_press and o_key_lvl SHALL rise in the same cycle; o_key_release and the fall of o_key_lvl SHALL coincide.
REQ-025 Acceptance latency from the stable input: 2 cycles of synchronizer, plus DEBOUNCE_MS ticks counted after entering the CHK state, plus 1 register cycle.
REQ-026 Counter SHALL never exceed DEBOUNCE_MS-1; no wrap-around is possible.
REQ-027 Several channels MAY pulse in the same cycle.

Reset
REQ-028 While i_rst = 1, every FSM SHALL be in IDLE, all counters and synchronizer-derived state cleared, and all outputs 0, regardless of i_clk.
REQ-029 Reset asserted mid-debounce SHALL discard progress; after release a key held low SHALL require a full new DEBOUNCE_MS interval and SHALL produce one o_key_press.
REQ-030 Reset SHALL NOT produce any o_key_release pulse.

Verification (DEBOUNCE_MS = 3 for sim speed; i_pls_1k every 10 cycles)
REQ-031 Clean press: key0 driven 0 and held -> o_key_press[0] one-cycle pulse after the 3rd tick following PRESS_CHK entry, o_key_lvl[0] = 1 thereafter, other bits 0.
REQ-032 Bounce: key0 toggles 0/1 every 7 cycles for 60 cycles, then returns to 1 -> no pulses, o_key_lvl[0] stays 0.
REQ-033 Release: from HELD, key0 driven 1 and held -> o_key_release[0] pulse after 3 ticks, o_key_lvl[0] = 0 in the same cycle.
REQ-034 Tick/abort collision: in PRESS_CHK with counter = 2, key returns to 1 in the same cycle as the tick -> FSM to IDLE, no press pulse.
REQ-035 Simultaneous keys: key0 and key3 driven 0 in the same cycle -> o_key_press = 4'b1001 in a single cycle.
REQ-036 Mid-operation reset: i_rst pulsed while key1 in PRESS_CHK with key1 held low -> outputs 0 during reset; exactly one o_key_press[1] after 3 new ticks.
